// File: rtl/df_stim_master_pkg.sv
// Shared types and constants for the filter stimulus master and its noise generator.
package df_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCfgSetup,
        StCfgEn,
        StCfgHold,
        StRun,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        PatImpulse = 2'b00,
        PatStep    = 2'b01,
        PatRamp    = 2'b10,
        PatLfsr    = 2'b11
    } pattern_e;

    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned EN_CYC    = 4;
    localparam int unsigned HOLD_CYC  = 2;
    localparam int unsigned CNT_W     = 3;

    localparam int unsigned             LFSR_W    = 8;
    // x^8+x^6+x^5+x^4+1 as bit positions 7,5,4,3
    localparam logic [LFSR_W-1:0]       LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/df_stim_master_if.sv
// Run-request and filter-side signal bundle for df_stim_master.
interface df_stim_master_if;
    logic       start;
    logic [2:0] cfg_val;
    logic [1:0] pattern;
    logic [7:0] amp;
    logic [3:0] rate_div;
    logic [7:0] num_samples;
    logic       enconfig;
    logic [2:0] configin;
    logic [7:0] datain;
    logic       sample_stb;
    logic       busy;
    logic       done;

    modport master (
        input  start, cfg_val, pattern, amp, rate_div, num_samples,
        output enconfig, configin, datain, sample_stb, busy, done
    );

    modport slave (
        output start, cfg_val, pattern, amp, rate_div, num_samples,
        input  enconfig, configin, datain, sample_stb, busy, done
    );
endinterface

// File: rtl/df_lfsr8.sv
// 8-bit Fibonacci LFSR noise source; a zero seed is replaced by 1 to avoid lock-up.
module df_lfsr8
    import df_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_advance,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb    = ^(r_state & LFSR_TAPS);
    assign o_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (i_advance) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/df_stim_master.sv
// Programs a filter config word with a setup/strobe/hold sequence, then streams a
// selectable stimulus pattern. All outputs are registered from next-state values.
module df_stim_master
    import df_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    df_stim_master_if.master bus
);

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [3:0]       r_hold, w_hold_d;
    logic [8:0]       r_left, w_left_d;
    logic [7:0]       r_acc, w_acc_d;
    logic [2:0]       r_cfg, w_cfg_d;
    pattern_e         r_pat, w_pat_d;
    logic [7:0]       r_amp, w_amp_d;
    logic [3:0]       r_rate, w_rate_d;
    logic [7:0]       r_num, w_num_d;

    logic             r_enconfig, w_enconfig_d;
    logic [2:0]       r_configin, w_configin_d;
    logic [7:0]       r_datain, w_datain_d;
    logic             r_stb, w_stb_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;

    logic             w_load, w_new, w_first;
    logic [7:0]       w_lfsr;

    df_lfsr8 u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_seed    (bus.amp),
        .i_advance (w_new),
        .o_state   (w_lfsr)
    );

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_hold_d   = r_hold;
        w_left_d   = r_left;
        w_acc_d    = r_acc;
        w_cfg_d    = r_cfg;
        w_pat_d    = r_pat;
        w_amp_d    = r_amp;
        w_rate_d   = r_rate;
        w_num_d    = r_num;
        w_datain_d = r_datain;
        w_load     = 1'b0;
        w_new      = 1'b0;
        w_first    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_cfg_d   = bus.cfg_val;
                    w_pat_d   = pattern_e'(bus.pattern);
                    w_amp_d   = bus.amp;
                    w_rate_d  = bus.rate_div;
                    w_num_d   = bus.num_samples;
                    w_acc_d   = '0;
                    w_load    = 1'b1;
                    w_cnt_d   = CNT_W'(SETUP_CYC - 1);
                    w_state_d = StCfgSetup;
                end
            end
            StCfgSetup: begin
                if (r_cnt == '0) begin
                    w_cnt_d   = CNT_W'(EN_CYC - 1);
                    w_state_d = StCfgEn;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StCfgEn: begin
                if (r_cnt == '0) begin
                    w_cnt_d   = CNT_W'(HOLD_CYC - 1);
                    w_state_d = StCfgHold;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StCfgHold: begin
                if (r_cnt == '0) begin
                    w_new     = 1'b1;
                    w_first   = 1'b1;
                    w_hold_d  = r_rate;
                    w_left_d  = (r_num == '0) ? 9'd256 : {1'b0, r_num};
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StRun: begin
                if (r_hold != '0) begin
                    w_hold_d = r_hold - 4'd1;
                end else if (r_left == 9'd1) begin
                    w_state_d = StDone;
                end else begin
                    w_new    = 1'b1;
                    w_hold_d = r_rate;
                    w_left_d = r_left - 9'd1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // Generators run one sample ahead: the value presented now is taken before advancing.
        if (w_new) begin
            w_acc_d = r_acc + r_amp;
            unique case (r_pat)
                PatImpulse: w_datain_d = w_first ? r_amp : 8'h00;
                PatStep:    w_datain_d = r_amp;
                PatRamp:    w_datain_d = r_acc;
                PatLfsr:    w_datain_d = w_lfsr;
            endcase
        end
        if (w_state_d != StRun) begin
            w_datain_d = '0;
        end

        w_stb_d      = w_new;
        w_enconfig_d = (w_state_d == StCfgEn);
        w_configin_d = (w_state_d inside {StCfgSetup, StCfgEn, StCfgHold}) ? w_cfg_d : '0;
        w_busy_d     = (w_state_d != StIdle);
        w_done_d     = (w_state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_left     <= '0;
            r_acc      <= '0;
            r_cfg      <= '0;
            r_pat      <= PatImpulse;
            r_amp      <= '0;
            r_rate     <= '0;
            r_num      <= '0;
            r_enconfig <= 1'b0;
            r_configin <= '0;
            r_datain   <= '0;
            r_stb      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_hold     <= w_hold_d;
            r_left     <= w_left_d;
            r_acc      <= w_acc_d;
            r_cfg      <= w_cfg_d;
            r_pat      <= w_pat_d;
            r_amp      <= w_amp_d;
            r_rate     <= w_rate_d;
            r_num      <= w_num_d;
            r_enconfig <= w_enconfig_d;
            r_configin <= w_configin_d;
            r_datain   <= w_datain_d;
            r_stb      <= w_stb_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign bus.enconfig   = r_enconfig;
    assign bus.configin   = r_configin;
    assign bus.datain     = r_datain;
    assign bus.sample_stb = r_stb;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_df_stim_master.sv
// Directed bench for df_stim_master: cycle tables for config/impulse and ramp runs,
// plus hand sequences for LFSR/256 samples, ignored starts and mid-strobe reset.
module tb_df_stim_master;
    import df_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    df_stim_master_if u_if ();

    df_stim_master u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sc;
        int cyc;
        int cfg;
        int en;
        int data;
        int stb;
        int busy;
        int done;
    } vec_t;

    vec_t vecs[$];
    int   cap_cfg [2][40];
    int   cap_en  [2][40];
    int   cap_data[2][40];
    int   cap_stb [2][40];
    int   cap_busy[2][40];
    int   cap_done[2][40];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void add(input int sc, input int cyc, input int cfg, input int en,
                                input int data, input int stb, input int busy, input int done);
        vecs.push_back('{sc, cyc, cfg, en, data, stb, busy, done});
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int sc, input int k);
        cap_cfg[sc][k]  = int'(u_if.configin);
        cap_en[sc][k]   = int'(u_if.enconfig);
        cap_data[sc][k] = int'(u_if.datain);
        cap_stb[sc][k]  = int'(u_if.sample_stb);
        cap_busy[sc][k] = int'(u_if.busy);
        cap_done[sc][k] = int'(u_if.done);
    endtask

    // Index k of a capture is cycle t+k, where t is the edge that samples start.
    task automatic launch(input int sc, input logic [2:0] cfg, input logic [1:0] pat,
                          input logic [7:0] amp, input logic [3:0] rate, input logic [7:0] num,
                          input int ncyc);
        u_if.cfg_val     = cfg;
        u_if.pattern     = pat;
        u_if.amp         = amp;
        u_if.rate_div    = rate;
        u_if.num_samples = num;
        u_if.start       = 1'b1;
        snap(sc, 0);
        tick();
        u_if.start       = 1'b0;
        u_if.cfg_val     = ~cfg;
        u_if.pattern     = ~pat;
        u_if.amp         = ~amp;
        u_if.rate_div    = ~rate;
        u_if.num_samples = ~num;
        for (int k = 1; k < ncyc; k++) begin
            snap(sc, k);
            tick();
        end
    endtask

    task automatic check_table(input int sc);
        foreach (vecs[i]) begin
            if (vecs[i].sc == sc) begin
                chk($sformatf("sc%0d t+%0d configin", sc, vecs[i].cyc),
                    cap_cfg[sc][vecs[i].cyc], vecs[i].cfg);
                chk($sformatf("sc%0d t+%0d enconfig", sc, vecs[i].cyc),
                    cap_en[sc][vecs[i].cyc], vecs[i].en);
                chk($sformatf("sc%0d t+%0d datain", sc, vecs[i].cyc),
                    cap_data[sc][vecs[i].cyc], vecs[i].data);
                chk($sformatf("sc%0d t+%0d sample_stb", sc, vecs[i].cyc),
                    cap_stb[sc][vecs[i].cyc], vecs[i].stb);
                chk($sformatf("sc%0d t+%0d busy", sc, vecs[i].cyc),
                    cap_busy[sc][vecs[i].cyc], vecs[i].busy);
                chk($sformatf("sc%0d t+%0d done", sc, vecs[i].cyc),
                    cap_done[sc][vecs[i].cyc], vecs[i].done);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " enconfig"}, int'(u_if.enconfig), 0);
        chk({tag, " configin"}, int'(u_if.configin), 0);
        chk({tag, " datain"}, int'(u_if.datain), 0);
        chk({tag, " sample_stb"}, int'(u_if.sample_stb), 0);
        chk({tag, " busy"}, int'(u_if.busy), 0);
        chk({tag, " done"}, int'(u_if.done), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_stb, n_done, n_busy, d0, d1, d2;
        bit  seen;

        // Scenario 0: cfg 5, impulse amp 0x40, rate 0, N=4.
        add(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 2; c++) add(0, c, 5, 0, 0, 0, 1, 0);
        for (int c = 3; c <= 6; c++) add(0, c, 5, 1, 0, 0, 1, 0);
        for (int c = 7; c <= 8; c++) add(0, c, 5, 0, 0, 0, 1, 0);
        add(0, 9, 0, 0, 'h40, 1, 1, 0);
        for (int c = 10; c <= 12; c++) add(0, c, 0, 0, 0, 1, 1, 0);
        add(0, 13, 0, 0, 0, 0, 1, 1);
        add(0, 14, 0, 0, 0, 0, 0, 0);
        add(0, 15, 0, 0, 0, 0, 0, 0);
        // Scenario 1: cfg 3, ramp amp 0x60, rate 1, N=4.
        add(1, 2, 3, 0, 0, 0, 1, 0);
        add(1, 3, 3, 1, 0, 0, 1, 0);
        add(1, 8, 3, 0, 0, 0, 1, 0);
        add(1, 9, 0, 0, 'h00, 1, 1, 0);
        add(1, 10, 0, 0, 'h00, 0, 1, 0);
        add(1, 11, 0, 0, 'h60, 1, 1, 0);
        add(1, 12, 0, 0, 'h60, 0, 1, 0);
        add(1, 13, 0, 0, 'hC0, 1, 1, 0);
        add(1, 14, 0, 0, 'hC0, 0, 1, 0);
        add(1, 15, 0, 0, 'h20, 1, 1, 0);
        add(1, 16, 0, 0, 'h20, 0, 1, 0);
        add(1, 17, 0, 0, 0, 0, 1, 1);
        add(1, 18, 0, 0, 0, 0, 0, 0);

        rst_n            = 1'b0;
        u_if.start       = 1'b0;
        u_if.cfg_val     = '0;
        u_if.pattern     = '0;
        u_if.amp         = '0;
        u_if.rate_div    = '0;
        u_if.num_samples = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_all_zero("post-reset idle");

        launch(0, 3'd5, 2'b00, 8'h40, 4'd0, 8'd4, 16);
        check_table(0);
        tick();

        launch(1, 3'd3, 2'b10, 8'h60, 4'd1, 8'd4, 20);
        check_table(1);
        tick();

        // LFSR with zero seed and 256 samples.
        u_if.pattern     = 2'b11;
        u_if.amp         = 8'h00;
        u_if.rate_div    = 4'd0;
        u_if.num_samples = 8'd0;
        u_if.start       = 1'b1;
        tick();
        u_if.start = 1'b0;
        n_stb = 0;
        seen  = 1'b0;
        d0 = -1;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (u_if.sample_stb) begin
                if (n_stb == 0) d0 = int'(u_if.datain);
                if (n_stb == 1) d1 = int'(u_if.datain);
                if (n_stb == 2) d2 = int'(u_if.datain);
                n_stb++;
            end
            if (u_if.done) seen = 1'b1;
            else tick();
        end
        chk("lfsr done reached", int'(seen), 1);
        chk("lfsr stb count", n_stb, 256);
        chk("lfsr sample0", d0, 'h01);
        chk("lfsr sample1", d1, 'h02);
        chk("lfsr sample2", d2, 'h04);
        tick();
        tick();

        // Start pulses during RUN and DONE must be ignored.
        u_if.pattern     = 2'b01;
        u_if.amp         = 8'h11;
        u_if.rate_div    = 4'd0;
        u_if.num_samples = 8'd3;
        u_if.start       = 1'b1;
        tick();
        n_done = 0;
        n_busy = 0;
        for (int i = 1; i < 40; i++) begin
            u_if.start = (i == 10) || u_if.done;
            if (u_if.done) n_done++;
            if (u_if.busy) n_busy++;
            if (i == 10) chk("step datain in run", int'(u_if.datain), 'h11);
            tick();
        end
        u_if.start = 1'b0;
        chk("ignored start done count", n_done, 1);
        chk("ignored start busy cycles", n_busy, 12);

        // Reset asserted during CFG_EN.
        u_if.cfg_val = 3'd6;
        u_if.start   = 1'b1;
        tick();
        u_if.start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre-reset enconfig", int'(u_if.enconfig), 1);
        chk("pre-reset configin", int'(u_if.configin), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        tick();
        tick();
        rst_n  = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (u_if.done) n_done++;
            if (u_if.busy) n_busy++;
            tick();
        end
        chk("after reset done", n_done, 0);
        chk("after reset busy", n_busy, 0);

        launch(0, 3'd5, 2'b00, 8'h40, 4'd0, 8'd4, 16);
        check_table(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
